// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller and the datapath it drives.
package ctrl_pkg;

  localparam int STATE_W = 5;
  localparam int OPC_W   = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 5'd0,
    S_DECODE = 5'd1,
    S_ADDR   = 5'd2,
    S_MEM_RD = 5'd3,
    S_WB_MEM = 5'd4,
    S_MEM_WR = 5'd5,
    S_EXEC_R = 5'd6,
    S_EXEC_I = 5'd7,
    S_WB_ALU = 5'd8,
    S_BRANCH = 5'd9,
    S_JUMP   = 5'd10,
    S_TRAP   = 5'd31
  } state_t;

  localparam logic [OPC_W-1:0] OP_AND  = 6'd0;
  localparam logic [OPC_W-1:0] OP_ADD  = 6'd1;
  localparam logic [OPC_W-1:0] OP_SUB  = 6'd2;
  localparam logic [OPC_W-1:0] OP_ANDI = 6'd3;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'd4;
  localparam logic [OPC_W-1:0] OP_LW   = 6'd5;
  localparam logic [OPC_W-1:0] OP_SW   = 6'd6;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'd7;
  localparam logic [OPC_W-1:0] OP_BNE  = 6'd8;
  localparam logic [OPC_W-1:0] OP_J    = 6'd9;
  localparam logic [OPC_W-1:0] OP_JAL  = 6'd10;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // Full control bus towards the datapath.
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       addr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       illegal;
  } ctrl_t;

  // Step that follows DECODE for a given opcode.
  function automatic state_t decode_next(input logic [OPC_W-1:0] op);
    if (op <= OP_SUB)      return S_EXEC_R;
    else if (op <= OP_ADDI) return S_EXEC_I;
    else if (op <= OP_SW)   return S_ADDR;
    else if (op <= OP_BNE)  return S_BRANCH;
    else if (op <= OP_JAL)  return S_JUMP;
    else                    return S_TRAP;
  endfunction

endpackage

// File: rtl/control_outputs.sv
// Combinational decoder from controller state (plus opcode and flags) to the control bus.
module control_outputs
  import ctrl_pkg::*;
(
  input  state_t           state,
  input  logic [OPC_W-1:0] op_code,
  input  logic             zero,
  input  logic             mem_ready,
  output ctrl_t            ctrl
);

  // Per-state control values; anything not set stays 0.
  always_comb begin
    // NOTE: assigning the whole bus a default first keeps every path fully specified, so no latch is inferred.
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.addr_src = 1'b0;
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.alu_src_a = 1'b0;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_src    = PC_ALU;
        end
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut.
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.ext_sel   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        if (op_code == OP_AND)      ctrl.alu_op = ALU_AND;
        else if (op_code == OP_SUB) ctrl.alu_op = ALU_SUB;
        else                        ctrl.alu_op = ALU_ADD;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        if (op_code == OP_ANDI) begin
          ctrl.alu_op  = ALU_AND;
          ctrl.ext_sel = 1'b0;
        end else begin
          ctrl.alu_op  = ALU_ADD;
          ctrl.ext_sel = 1'b1;
        end
      end
      S_WB_ALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_src    = WB_ALUOUT;
        ctrl.reg_dst   = (op_code <= OP_SUB) ? RD_RD : RD_RT;
      end
      S_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_sel   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.addr_src = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_src    = WB_MDR;
        ctrl.reg_dst   = RD_RT;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.addr_src  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.pc_write  = (op_code == OP_BEQ) ? zero : ~zero;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_JUMP;
        if (op_code == OP_JAL) begin
          // PC already holds PC+4, so it is the link value.
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = RD_R31;
          ctrl.wb_src    = WB_PC;
        end
      end
      S_TRAP: ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle main controller: instruction-step state register, next-state logic and output decode.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 5,
  parameter int OPC_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   op_code,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               ir_write,
  output logic               addr_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               ext_sel,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl_raw, ctrl;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values, independent of block order.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state sequencing; memory steps wait on mem_ready, TRAP only exits through rst.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = decode_next(op_code);
      S_EXEC_R: state_d = S_WB_ALU;
      S_EXEC_I: state_d = S_WB_ALU;
      S_WB_ALU: state_d = S_FETCH;
      S_ADDR:   state_d = (op_code == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  control_outputs u_outputs (
    .state     (state_q),
    .op_code   (op_code),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_raw)
  );

  // Quiet bus while rst is held so no request leaks from the state being abandoned.
  always_comb begin
    ctrl = rst ? '0 : ctrl_raw;
  end

  assign pc_write  = ctrl.pc_write;
  assign pc_src    = ctrl.pc_src;
  assign ir_write  = ctrl.ir_write;
  assign addr_src  = ctrl.addr_src;
  assign mem_read  = ctrl.mem_read;
  assign mem_write = ctrl.mem_write;
  assign reg_write = ctrl.reg_write;
  assign reg_dst   = ctrl.reg_dst;
  assign wb_src    = ctrl.wb_src;
  assign alu_src_a = ctrl.alu_src_a;
  assign alu_src_b = ctrl.alu_src_b;
  assign alu_op    = ctrl.alu_op;
  assign ext_sel   = ctrl.ext_sel;
  assign illegal   = ctrl.illegal;
  assign state     = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for the multicycle controller.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op_code;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, addr_src, mem_read, mem_write, reg_write;
  logic       alu_src_a, ext_sel, illegal;
  logic [1:0] pc_src, reg_dst, wb_src, alu_src_b;
  logic [2:0] alu_op;
  logic [4:0] state;

  int tests  = 0;
  int errors = 0;

  control_unit dut (
    .clk       (clk),
    .rst       (rst),
    .op_code   (op_code),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .ir_write  (ir_write),
    .addr_src  (addr_src),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .wb_src    (wb_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .ext_sel   (ext_sel),
    .illegal   (illegal),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic       z;
    logic       rdy;
    logic [4:0] st;
    logic [19:0] ctl;
  } vec_t;

  vec_t vecs[$];

  // Expected bus, field order matching got_ctl().
  function automatic logic [19:0] ctl(input logic pcw, input logic [1:0] pcs, input logic irw,
                                      input logic as, input logic mr, input logic mw, input logic rw,
                                      input logic [1:0] rd, input logic [1:0] wb, input logic sa,
                                      input logic [1:0] sb, input logic [2:0] aop, input logic ext,
                                      input logic ill);
    return {pcw, pcs, irw, as, mr, mw, rw, rd, wb, sa, sb, aop, ext, ill};
  endfunction

  function automatic logic [19:0] got_ctl();
    return {pc_write, pc_src, ir_write, addr_src, mem_read, mem_write, reg_write,
            reg_dst, wb_src, alu_src_a, alu_src_b, alu_op, ext_sel, illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input string name, input logic [5:0] op, input logic z, input logic rdy,
                     input logic [4:0] st, input logic [19:0] c);
    vec_t v;
    v.name = name; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ctl = c;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [19:0] f_rdy, f_wait, dec, adr, mrd, wbm, mwr, jmp, jal, trp, zero_ctl;

  initial begin
    f_rdy    = ctl(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    f_wait   = ctl(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    dec      = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0);
    adr      = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0);
    mrd      = ctl(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wbm      = ctl(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    mwr      = ctl(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    jmp      = ctl(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    jal      = ctl(1, 2, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0);
    trp      = ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    zero_ctl = '0;

    // ADD: 0,1,6,8
    add("add_fetch", 1, 0, 1, 0, f_rdy);
    add("add_dec",   1, 0, 1, 1, dec);
    add("add_exec",  1, 0, 1, 6, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add("add_wb",    1, 0, 1, 8, ctl(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    // AND (R-type)
    add("and_fetch", 0, 0, 1, 0, f_rdy);
    add("and_dec",   0, 0, 1, 1, dec);
    add("and_exec",  0, 0, 1, 6, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0));
    add("and_wb",    0, 0, 1, 8, ctl(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    // ANDI: zero-extend, rt destination
    add("andi_fetch", 3, 0, 1, 0, f_rdy);
    add("andi_dec",   3, 0, 1, 1, dec);
    add("andi_exec",  3, 0, 1, 7, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0));
    add("andi_wb",    3, 0, 1, 8, ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // ADDI: sign-extend
    add("addi_fetch", 4, 0, 1, 0, f_rdy);
    add("addi_dec",   4, 0, 1, 1, dec);
    add("addi_exec",  4, 0, 1, 7, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0));
    add("addi_wb",    4, 0, 1, 8, ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // LW with one FETCH stall and two MEM_RD stalls
    add("lw_fwait",  5, 0, 0, 0, f_wait);
    add("lw_fetch",  5, 0, 1, 0, f_rdy);
    add("lw_dec",    5, 0, 1, 1, dec);
    add("lw_addr",   5, 0, 1, 2, adr);
    add("lw_rd0",    5, 0, 0, 3, mrd);
    add("lw_rd1",    5, 0, 0, 3, mrd);
    add("lw_rd2",    5, 0, 1, 3, mrd);
    add("lw_wb",     5, 0, 1, 4, wbm);
    // BEQ / BNE, taken and not taken
    add("beq1_fetch", 7, 1, 1, 0, f_rdy);
    add("beq1_dec",   7, 1, 1, 1, dec);
    add("beq1_br",    7, 1, 1, 9, ctl(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    add("beq0_fetch", 7, 0, 1, 0, f_rdy);
    add("beq0_dec",   7, 0, 1, 1, dec);
    add("beq0_br",    7, 0, 1, 9, ctl(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    add("bne1_fetch", 8, 1, 1, 0, f_rdy);
    add("bne1_dec",   8, 1, 1, 1, dec);
    add("bne1_br",    8, 1, 1, 9, ctl(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    add("bne0_fetch", 8, 0, 1, 0, f_rdy);
    add("bne0_dec",   8, 0, 1, 1, dec);
    add("bne0_br",    8, 0, 1, 9, ctl(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    // J and JAL
    add("j_fetch",   9, 0, 1, 0, f_rdy);
    add("j_dec",     9, 0, 1, 1, dec);
    add("j_jump",    9, 0, 1, 10, jmp);
    add("jal_fetch", 10, 0, 1, 0, f_rdy);
    add("jal_dec",   10, 0, 1, 1, dec);
    add("jal_jump",  10, 0, 1, 10, jal);
    // SW with one MEM_WR stall
    add("sw_fetch",  6, 0, 1, 0, f_rdy);
    add("sw_dec",    6, 0, 1, 1, dec);
    add("sw_addr",   6, 0, 1, 2, adr);
    add("sw_wr0",    6, 0, 0, 5, mwr);
    add("sw_wr1",    6, 0, 1, 5, mwr);
    add("sw_done",   6, 0, 0, 0, f_wait);
  end

  initial begin
    rst = 1'b1; op_code = '0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    repeat (2) next_cycle();
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctl",   32'(got_ctl()), 32'(zero_ctl));
    rst = 1'b0;
    #1;

    // Table: each record is one cycle, checked just before the next rising edge.
    foreach (vecs[i]) begin
      op_code = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #1;
      check({vecs[i].name, "_state"}, 32'(state), 32'(vecs[i].st));
      check({vecs[i].name, "_ctl"},   32'(got_ctl()), 32'(vecs[i].ctl));
      next_cycle();
    end

    // SW: rst while waiting in MEM_WR; no write survives.
    op_code = 6; mem_ready = 1'b0;
    check("swr_fetch_state", 32'(state), 32'd0);
    mem_ready = 1'b1; #1; next_cycle();
    check("swr_dec_state", 32'(state), 32'd1);
    next_cycle();
    check("swr_addr_state", 32'(state), 32'd2);
    mem_ready = 1'b0; next_cycle();
    #1;
    check("swr_wait_state", 32'(state), 32'd5);
    check("swr_wait_mw",    32'(mem_write), 32'd1);
    rst = 1'b1; #1;
    check("swr_rst_mw", 32'(mem_write), 32'd0);
    next_cycle();
    rst = 1'b0; #1;
    check("swr_after_state", 32'(state), 32'd0);
    check("swr_after_ctl",   32'(got_ctl()), 32'(f_wait));

    // Illegal opcode: TRAP holds for 20 cycles until rst.
    op_code = 63; mem_ready = 1'b1; #1;
    next_cycle();
    check("ill_dec_state", 32'(state), 32'd1);
    check("ill_dec_ctl",   32'(got_ctl()), 32'(dec));
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      check($sformatf("trap_state_%0d", k), 32'(state), 32'd31);
      check($sformatf("trap_ctl_%0d", k),   32'(got_ctl()), 32'(trp));
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; mem_ready = 1'b0; #1;
    check("trap_rst_state", 32'(state), 32'd0);
    check("trap_rst_ill",   32'(illegal), 32'd0);
    check("trap_rst_ctl",   32'(got_ctl()), 32'(f_wait));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
